// File: rtl/uart_cmd_responder.sv
// Command responder that parses A5-framed UART requests and reads/writes a small register bank.
// Optional trailing XOR checksum byte is enabled by defining UART_CMD_CHECKSUM_EN.
module uart_cmd_responder #(
    parameter int unsigned NUM_REGS     = 8,
    parameter int unsigned TIMEOUT_CLKS = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    output logic [7:0] reg0,
    output logic       busy,
    output logic       frame_timeout
);

    localparam int unsigned CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);

    localparam logic [7:0] SYNC    = 8'hA5;
    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMD  = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
`ifdef UART_CMD_CHECKSUM_EN
    localparam logic [2:0] S_CSUM = 3'd4;
`endif
    localparam logic [2:0] S_EXEC = 3'd5;
    localparam logic [2:0] S_SEND = 3'd6;
    localparam logic [2:0] S_WAIT = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic             nak_q, nak_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_start_q, tx_start_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic [7:0]       regs_q [NUM_REGS];
    logic             wr_en_c;
    logic [7:0]       rd_data_c;
    logic             addr_ok_c;
    logic             csum_ok_c;
    logic [2:0]       after_payload_c;

`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
    assign csum_ok_c       = (csum_q == (cmd_q ^ addr_q ^ ((cmd_q == CMD_WR) ? data_q : 8'h00)));
    assign after_payload_c = S_CSUM;
`else
    assign csum_ok_c       = 1'b1;
    assign after_payload_c = S_EXEC;
`endif

    // Address is compared at 9 bits so NUM_REGS=256 and addr=0xFF both behave.
    assign addr_ok_c = ({1'b0, addr_q} < 9'(NUM_REGS));

    always_comb begin
        rd_data_c = 8'h00;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (addr_q == 8'(i)) rd_data_c = regs_q[i];
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        data_d    = data_q;
        nak_d     = nak_q;
        tx_data_d = tx_data_q;
        timeout_d = 1'b0;
        wr_en_c   = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rx_valid && (rx_byte == SYNC)) begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                    nak_d   = 1'b0;
                    data_d  = 8'h00;
                end
            end
            S_EXEC: begin
                state_d = S_SEND;
                if (nak_q || !addr_ok_c || !csum_ok_c) begin
                    tx_data_d = RSP_NAK;
                end else if (cmd_q == CMD_WR) begin
                    tx_data_d = RSP_ACK;
                    wr_en_c   = 1'b1;
                end else begin
                    tx_data_d = rd_data_c;
                end
            end
            S_SEND: state_d = S_WAIT;
            S_WAIT: begin
                if (tx_done) state_d = S_IDLE;
            end
            default: begin
                // Frame-collection states share the inter-byte timeout; a byte at expiry wins.
                if (rx_valid) begin
                    cnt_d = '0;
                    case (state_q)
                        S_CMD: begin
                            cmd_d = rx_byte;
                            if ((rx_byte == CMD_WR) || (rx_byte == CMD_RD)) begin
                                state_d = S_ADDR;
                            end else begin
                                nak_d   = 1'b1;
                                state_d = S_EXEC;
                            end
                        end
                        S_ADDR: begin
                            addr_d  = rx_byte;
                            state_d = (cmd_q == CMD_WR) ? S_DATA : after_payload_c;
                        end
                        S_DATA: begin
                            data_d  = rx_byte;
                            state_d = after_payload_c;
                        end
`ifdef UART_CMD_CHECKSUM_EN
                        S_CSUM: begin
                            csum_d  = rx_byte;
                            state_d = S_EXEC;
                        end
`endif
                        default: state_d = S_IDLE;
                    endcase
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
        tx_start_d = (state_d == S_SEND);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cmd_q      <= 8'h00;
            addr_q     <= 8'h00;
            data_q     <= 8'h00;
            nak_q      <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            nak_q      <= nak_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
`ifdef UART_CMD_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // Register bank; the write lands on the edge leaving EXEC, alongside tx_start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
        end else if (wr_en_c) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (addr_q == 8'(i)) regs_q[i] <= data_q;
            end
        end
    end

    assign tx_start      = tx_start_q;
    assign tx_data       = tx_data_q;
    assign reg0          = regs_q[0];
    assign busy          = busy_q;
    assign frame_timeout = timeout_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Randomized scoreboard bench for uart_cmd_responder: stimulus pushes expected responses,
// a monitor pops and compares on every tx_start, and a transmitter model returns tx_done.
module tb_uart_cmd_responder;

    localparam int unsigned NREGS = 8;
    localparam int unsigned TMO   = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic       tx_done = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [7:0] reg0;
    logic       busy;
    logic       frame_timeout;

    uart_cmd_responder #(.NUM_REGS(NREGS), .TIMEOUT_CLKS(TMO)) dut (
        .clk(clk), .reset(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
        .reg0(reg0), .busy(busy), .frame_timeout(frame_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rsp;
        logic [7:0] r0;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] m_regs [NREGS];
    int         n_cmp = 0;
    int         n_err = 0;
    int         to_seen = 0;
    int         exp_to = 0;
    bit         hold_done = 1'b0;
    bit         abort_tx = 1'b0;
    bit         pend = 1'b0;
    logic [7:0] pend_data = 8'h00;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (frame_timeout) to_seen++;
            if (pend && !tx_start) check8("tx_data_stable", tx_data, pend_data);
            if (tx_done) pend = 1'b0;
            if (tx_start) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL tx_start_unexpected: tx_data %02h with no frame pending (t=%0t)", tx_data, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check8("tx_data", tx_data, mon_e.rsp);
                    check8("reg0_at_tx_start", reg0, mon_e.r0);
                    pend      = 1'b1;
                    pend_data = mon_e.rsp;
                end
            end
        end
    end

    // Transmitter model, with an occasional stray tx_done after the real one.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && tx_start) begin
                while (hold_done) @(negedge clk);
                if (!abort_tx) begin
                    repeat ($urandom_range(0, 5)) @(posedge clk);
                    @(posedge clk); #1 tx_done = 1'b1;
                    @(posedge clk); #1 tx_done = 1'b0;
                    if ($urandom_range(0, 1) == 1) begin
                        @(posedge clk); #1 tx_done = 1'b1;
                        @(posedge clk); #1 tx_done = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        @(negedge clk);
        while (busy && k < 300) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (busy) begin
            n_err++;
            $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, k);
        end
        @(posedge clk); #1;
    endtask

    // Builds one frame, predicts the response from the command rules, and sends it.
    task automatic do_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data,
                            input bit bad_csum, input bit hold, input int gap1);
        logic [7:0] fb[$];
        logic [7:0] rsp;
        bit         is_w = (cmd == 8'h57);
        bit         is_r = (cmd == 8'h52);
        bit         csum_bad = 1'b0;
        exp_t       e;
        fb.push_back(8'hA5);
        fb.push_back(cmd);
        if (is_w || is_r) begin
            fb.push_back(addr);
            if (is_w) fb.push_back(data);
`ifdef UART_CMD_CHECKSUM_EN
            fb.push_back((cmd ^ addr ^ (is_w ? data : 8'h00)) ^ (bad_csum ? 8'h01 : 8'h00));
            csum_bad = bad_csum;
`endif
        end
        if (!is_w && !is_r)                       rsp = 8'h15;
        else if (addr >= NREGS || csum_bad)       rsp = 8'h15;
        else if (is_w) begin
            m_regs[int'(addr)] = data;
            rsp = 8'h06;
        end else                                  rsp = m_regs[int'(addr)];
        e.rsp = rsp;
        e.r0  = m_regs[0];
        exp_q.push_back(e);
        for (int i = 0; i < fb.size(); i++) begin
            int gap;
            if (i == fb.size() - 1)      gap = 0;
            else if (i == 1 && gap1 >= 0) gap = gap1;
            else                          gap = $urandom_range(0, 4);
            send_byte(fb[i], gap);
            if (i == 0) check8("busy_after_sync", 8'(busy), 8'h01);
        end
        @(negedge clk);
        check8("tx_start_in_exec", 8'(tx_start), 8'h00);
        @(negedge clk);
        check8("tx_start_latency", 8'(tx_start), 8'h01);
        if (hold) begin
            @(posedge clk); #1;
        end else begin
            wait_idle("busy_fall");
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check8("rst_busy", 8'(busy), 8'h00);
        check8("rst_reg0", reg0, 8'h00);
        check8("rst_tx_start", 8'(tx_start), 8'h00);
        check8("rst_tx_data", tx_data, 8'h00);
        check8("rst_frame_timeout", 8'(frame_timeout), 8'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases from the command rules.
        do_frame(8'h57, 8'h03, 8'hC3, 1'b0, 1'b0, -1);
        do_frame(8'h52, 8'h03, 8'h00, 1'b0, 1'b0, -1);
        do_frame(8'h57, 8'h00, 8'h5A, 1'b0, 1'b0, -1);
        do_frame(8'h41, 8'h00, 8'h00, 1'b0, 1'b0, -1);
        do_frame(8'h57, 8'h08, 8'h11, 1'b0, 1'b0, -1);
        do_frame(8'h52, 8'h08, 8'h00, 1'b0, 1'b0, -1);
        do_frame(8'h52, 8'h00, 8'h00, 1'b0, 1'b0, -1);
        do_frame(8'h57, 8'h07, 8'hA5, 1'b0, 1'b0, -1);
        do_frame(8'h52, 8'h07, 8'h00, 1'b0, 1'b0, -1);
        do_frame(8'h57, 8'hA5, 8'h33, 1'b0, 1'b0, -1);
        do_frame(8'h52, 8'hFF, 8'h00, 1'b0, 1'b0, -1);
        do_frame(8'h57, 8'h01, 8'h22, 1'b0, 1'b0, -1);
        do_frame(8'h57, 8'h01, 8'h99, 1'b1, 1'b0, -1);
        do_frame(8'h52, 8'h01, 8'h00, 1'b0, 1'b0, -1);

        // Abandoned frame: pulse after exactly TMO idle clocks, no response.
        send_byte(8'hA5, 0);
        send_byte(8'h57, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_timeout && n < int'(TMO) + 20);
        exp_to++;
        check8("timeout_delay", 8'(n), 8'(TMO + 1));
        @(negedge clk);
        check8("busy_after_timeout", 8'(busy), 8'h00);
        @(posedge clk); #1;
        do_frame(8'h52, 8'h00, 8'h00, 1'b0, 1'b0, -1);

        // Bytes arriving on the expiry cycle and just before it are kept.
        do_frame(8'h57, 8'h02, 8'h6B, 1'b0, 1'b0, int'(TMO) - 1);
        do_frame(8'h52, 8'h02, 8'h00, 1'b0, 1'b0, int'(TMO) - 2);

        // Bytes during WAIT_DONE are dropped.
        hold_done = 1'b1;
        do_frame(8'h52, 8'h03, 8'h00, 1'b0, 1'b1, -1);
        send_byte(8'hA5, 0);
        send_byte(8'h52, 0);
        send_byte(8'h00, 0);
        hold_done = 1'b0;
        wait_idle("busy_after_drop");
        repeat (10) begin
            @(posedge clk); #1;
        end

        // Reset between tx_start and tx_done.
        hold_done = 1'b1;
        do_frame(8'h57, 8'h05, 8'h77, 1'b0, 1'b1, -1);
        rst_n = 1'b0;
        #1;
        check8("midrsp_rst_busy", 8'(busy), 8'h00);
        check8("midrsp_rst_reg0", reg0, 8'h00);
        check8("midrsp_rst_tx_start", 8'(tx_start), 8'h00);
        for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
        abort_tx  = 1'b1;
        hold_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
        end
        abort_tx = 1'b0;
        do_frame(8'h52, 8'h05, 8'h00, 1'b0, 1'b0, -1);
        do_frame(8'h52, 8'h00, 8'h00, 1'b0, 1'b0, -1);

        // Randomized frames.
        for (int t = 0; t < 80; t++) begin
            logic [7:0] c, a, d;
            int r;
            r = $urandom_range(0, 9);
            if (r < 4)      c = 8'h57;
            else if (r < 8) c = 8'h52;
            else            c = 8'($urandom);
            r = $urandom_range(0, 9);
            if (r < 7)      a = 8'($urandom_range(0, NREGS - 1));
            else if (r < 8) a = 8'(NREGS);
            else if (r < 9) a = 8'hFF;
            else            a = 8'($urandom);
            d = 8'($urandom);
            do_frame(c, a, d, ($urandom_range(0, 5) == 0), 1'b0, -1);
        end

        repeat (20) begin
            @(posedge clk); #1;
        end
        check8("responses_outstanding", 8'(exp_q.size()), 8'h00);
        check8("timeout_pulses", 8'(to_seen), 8'(exp_to));
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
